barrier_wait_ctrl: RTL
======================

// Module: barrier_wait_ctrl
// PURPOSE
//  Per-core trigger-and-sleep controller placed directly downstream of the HW barrier unit.
//  A core issues a wait request; the block pulses that core's barrier trigger and gates its clock.
//  It buffers the core's barrier event and wakes the core with a one-cycle wake pulse.
//  An optional timeout wakes the core if no event arrives.
// PARAMETERS
//  NB_CORES  4  number of cores; width of every per-core vector
//  TIMEOUT   0  maximum SLEEP cycles before forced wake; 0 = timeout disabled
// PORTS
//  clk_i              in   1         clock
//  rst_i              in   1         synchronous, active-high reset
//  barrier_events_i   in   NB_CORES  barrier event per core (barrier unit events output)
//  wait_req_i         in   NB_CORES  per-core trigger-and-wait request, level, held until granted
//  wait_gnt_o         out  NB_CORES  request accepted; combinational
//  barrier_trigger_o  out  NB_CORES  registered 1-cycle trigger pulse to barrier unit trigger input
//  core_clk_en_o      out  NB_CORES  core clock enable; 0 while core waits
//  sleeping_o         out  NB_CORES  1 in TRIG or SLEEP
//  wake_valid_o       out  NB_CORES  1-cycle pulse: core released
//  wake_timeout_o     out  NB_CORES  qualifies wake_valid_o: 1 = woken by timeout
// BEHAVIOUR
//  - One independent FSM per core i: ACTIVE -> TRIG -> SLEEP -> WAKE -> ACTIVE. No shared state between cores.
//  - Reset (rst_i=1 at a clock edge), including mid-operation: all FSMs go to ACTIVE.
//    Event buffers and timeout counters clear.
//    Reset values: core_clk_en_o=1; all other outputs 0.
//  - ACTIVE: core_clk_en_o=1; wait_gnt_o[i]=wait_req_i[i].
//    On grant at cycle t: go to TRIG at t+1 and clear evt_buf[i].
//    Any barrier event at cycle t is dropped as stale.
//  - TRIG (single cycle): barrier_trigger_o[i]=1, core_clk_en_o=0; then go to SLEEP.
//  - SLEEP: core_clk_en_o=0; the timeout counter counts from 0 starting at SLEEP entry.
//    Exit to WAKE on (evt_buf[i] | barrier_events_i[i]).
//    If TIMEOUT>0, the counter is TIMEOUT-1 and there is no event: go to WAKE with the timeout flag set.
//  - WAKE (single cycle): core_clk_en_o=1, wake_valid_o=1, wake_timeout_o=timeout flag.
//    Clear evt_buf[i] and the counter; then go to ACTIVE.
//  - wait_gnt_o is 0 in TRIG, SLEEP and WAKE; the core holds the request.
//  - evt_buf[i] is set by barrier_events_i[i] in TRIG, SLEEP or WAKE.
//    Set has priority over clear, except at the ACTIVE grant.
//    Events arriving in ACTIVE (other than the grant cycle) are ignored.
//  - Event and timeout in the same cycle: event wins; wake_timeout_o=0.
//  - A SLEEP that ends by timeout lasts exactly TIMEOUT cycles.
//    The counter width is $clog2(TIMEOUT+1); it never wraps.
//  - Minimum round trip: grant at t, trigger at t+1, earliest wake_valid_o at t+3.
//    Event in TRIG cycle: the core wakes at t+3 via evt_buf.
//  - An event arriving after wake_valid_o, in ACTIVE, is lost by design.
//    A barrier is re-armed only through a new wait.
// TESTING
//  1. Reset: rst_i=1 for 2 cycles -> core_clk_en_o=4'hF, all other outputs 0, wait_gnt_o=0 while no req.
//  2. Core1 req at t=10, barrier_events_i=4'b0010 at t=14 ->
//     trigger_o=4'b0010 only at t=11; clk_en[1]=0 over t=11..14.
//     wake_valid_o[1] and wake_timeout_o[1]=0 at t=15; clk_en[1]=1 from t=15.
//  3. All 4 cores request in the same cycle; a single event 4'hF arrives 5 cycles later ->
//     all wake in the same cycle; no cross-core interference.
//  4. TIMEOUT=8, no event -> SLEEP exactly 8 cycles, then wake_valid_o=1 and wake_timeout_o=1.
//     Event at counter=7 -> wake_timeout_o=0.
//  5. Event at grant cycle t is dropped (core stays asleep).
//     Event in TRIG cycle t+1 -> wake_valid_o at t+3.
//  6. rst_i asserted while core0 in SLEEP -> next cycle clk_en[0]=1 and state ACTIVE.
//     A later event produces no wake_valid_o.

Source files
------------

// File: rtl/barrier_wait_ctrl.sv
// Per-core trigger-and-sleep controller downstream of the HW barrier unit.
// Each core runs its own ACTIVE -> TRIG -> SLEEP -> WAKE loop with an optional timeout.
module barrier_wait_ctrl #(
  parameter int NB_CORES = 4,
  parameter int TIMEOUT  = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NB_CORES-1:0] barrier_events_i,
  input  logic [NB_CORES-1:0] wait_req_i,
  output logic [NB_CORES-1:0] wait_gnt_o,
  output logic [NB_CORES-1:0] barrier_trigger_o,
  output logic [NB_CORES-1:0] core_clk_en_o,
  output logic [NB_CORES-1:0] sleeping_o,
  output logic [NB_CORES-1:0] wake_valid_o,
  output logic [NB_CORES-1:0] wake_timeout_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {ACTIVE, TRIG, SLEEP, WAKE} state_t;

  // Handshake: wait_req is a level held by the core; wait_gnt is high only in the
  // cycle the request is accepted (state ACTIVE), and the FSM leaves ACTIVE on that edge.
  for (genvar i = 0; i < NB_CORES; i++) begin : g_core
    state_t        state_q;
    logic          trig_q;
    logic          clk_en_q;
    logic          sleep_q;
    logic          wake_q;
    logic          wto_q;
    logic          evt_q;
    logic [CW-1:0] cnt_q;
    logic          ev;
    logic          timeout_hit;

    assign ev          = barrier_events_i[i];
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    assign wait_gnt_o[i]        = wait_req_i[i] && (state_q == ACTIVE);
    assign barrier_trigger_o[i] = trig_q;
    assign core_clk_en_o[i]     = clk_en_q;
    assign sleeping_o[i]        = sleep_q;
    assign wake_valid_o[i]      = wake_q;
    assign wake_timeout_o[i]    = wto_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q  <= ACTIVE;
        trig_q   <= 1'b0;
        clk_en_q <= 1'b1;
        sleep_q  <= 1'b0;
        wake_q   <= 1'b0;
        wto_q    <= 1'b0;
        evt_q    <= 1'b0;
        cnt_q    <= '0;
      end else begin
        trig_q <= 1'b0;
        wake_q <= 1'b0;
        wto_q  <= 1'b0;
        case (state_q)
          ACTIVE: begin
            // An event coinciding with the grant belongs to an older barrier: drop it.
            if (wait_req_i[i]) begin
              state_q  <= TRIG;
              trig_q   <= 1'b1;
              clk_en_q <= 1'b0;
              sleep_q  <= 1'b1;
              evt_q    <= 1'b0;
              cnt_q    <= '0;
            end
          end
          TRIG: begin
            state_q <= SLEEP;
            if (ev) evt_q <= 1'b1;
          end
          SLEEP: begin
            if (evt_q || ev) begin
              state_q  <= WAKE;
              wake_q   <= 1'b1;
              clk_en_q <= 1'b1;
              sleep_q  <= 1'b0;
              evt_q    <= 1'b1;
            end else if (timeout_hit) begin
              state_q  <= WAKE;
              wake_q   <= 1'b1;
              wto_q    <= 1'b1;
              clk_en_q <= 1'b1;
              sleep_q  <= 1'b0;
            end else if (TIMEOUT > 0) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          WAKE: begin
            state_q <= ACTIVE;
            evt_q   <= ev;
            cnt_q   <= '0;
          end
          default: state_q <= ACTIVE;
        endcase
      end
    end
  end

endmodule
